// File: rtl/riscv_pkg.sv
// Shared core constants plus register-file state and address helpers.
package riscv_pkg;

  localparam int unsigned XLEN      = 32;
  localparam int unsigned REG_SIZE  = 32;
  localparam int unsigned RF_NUM_RD = 2;
  localparam int unsigned RF_NUM_WR = 2;

  typedef enum logic {
    RF_CLEAR = 1'b0,
    RF_RUN   = 1'b1
  } rf_state_e;

  // Address names a real, writable register (in range, and not a hardwired x0).
  function automatic logic rf_addr_ok(input logic [31:0] addr,
                                      input int unsigned nregs,
                                      input bit          zero_x0);
    return (addr < nregs) && !(zero_x0 && (addr == 32'd0));
  endfunction

endpackage

// File: rtl/regfile_mp_scoreboard.sv
// Busy-bit scoreboard for regfile_mp: write-clear < alloc-set < flush, plus registered ready.
module rf_scoreboard #(
  parameter int unsigned NREGS   = 32,
  parameter int unsigned AW      = 5,
  parameter int unsigned NUM_RD  = 2,
  parameter int unsigned NUM_WR  = 2,
  parameter bit          ZERO_X0 = 1'b1,
  parameter bit          FWD_EN  = 1'b1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          clear_last,
  output logic                          ready,
  input  logic [NUM_WR-1:0]             wr_ok,
  input  logic [NUM_WR-1:0][AW-1:0]     wr_addr,
  input  logic                          alloc_en,
  input  logic [AW-1:0]                 alloc_addr,
  input  logic                          flush,
  input  logic [NUM_RD-1:0][AW-1:0]     rd_addr,
  input  logic [NUM_RD-1:0]             rd_ok,
  input  logic [NUM_RD-1:0]             rd_hit,
  output logic [NUM_RD-1:0]             rd_busy
);
  import riscv_pkg::*;

  logic [NREGS-1:0] busy;
  logic [NREGS-1:0] busy_n;

  always_comb begin
    busy_n = busy;
    if (ready) begin
      for (int unsigned i = 0; i < NUM_WR; i++) begin
        if (wr_ok[i]) busy_n[wr_addr[i]] = 1'b0;
      end
      if (alloc_en && rf_addr_ok(32'(alloc_addr), NREGS, ZERO_X0))
        busy_n[alloc_addr] = 1'b1;
      if (flush) busy_n = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy  <= '0;
      ready <= 1'b0;
    end else begin
      busy <= busy_n;
      if (clear_last) ready <= 1'b1;
    end
  end

  // A same-cycle write already forwards its value, so the reader need not wait.
  always_comb begin
    rd_busy = '0;
    for (int unsigned r = 0; r < NUM_RD; r++) begin
      rd_busy[r] = ready && rd_ok[r] && busy[rd_addr[r]] && !(FWD_EN && rd_hit[r]);
    end
  end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file: storage, write arbitration, forwarding and post-reset clear engine.
module regfile_mp #(
  parameter int unsigned XLEN    = riscv_pkg::XLEN,
  parameter int unsigned NREGS   = riscv_pkg::REG_SIZE,
  parameter int unsigned NUM_RD  = riscv_pkg::RF_NUM_RD,
  parameter int unsigned NUM_WR  = riscv_pkg::RF_NUM_WR,
  parameter bit          ZERO_X0 = 1'b1,
  parameter bit          FWD_EN  = 1'b1,
  parameter int unsigned AW      = $clog2(NREGS)
) (
  input  logic                          clk,
  input  logic                          rst,
  output logic                          ready,
  input  logic [NUM_RD-1:0][AW-1:0]     rd_addr,
  output logic [NUM_RD-1:0][XLEN-1:0]   rd_data,
  output logic [NUM_RD-1:0]             rd_busy,
  input  logic [NUM_WR-1:0]             wr_en,
  input  logic [NUM_WR-1:0][AW-1:0]     wr_addr,
  input  logic [NUM_WR-1:0][XLEN-1:0]   wr_data,
  input  logic                          alloc_en,
  input  logic [AW-1:0]                 alloc_addr,
  input  logic                          flush
);
  import riscv_pkg::*;

  localparam logic [AW-1:0] LAST = AW'(NREGS - 1);

  rf_state_e              state;
  logic [AW-1:0]          clr_ptr;
  logic [XLEN-1:0]        mem [NREGS];
  logic                   run;
  logic                   clear_last;
  logic [NUM_WR-1:0]      wr_ok;
  logic [NUM_RD-1:0]      rd_ok;
  logic [NUM_RD-1:0]      rd_hit;
  logic [XLEN-1:0]        fwd_data [NUM_RD];

  assign run        = (state == RF_RUN);
  assign clear_last = (state == RF_CLEAR) && (clr_ptr == LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= RF_CLEAR;
      clr_ptr <= '0;
    end else if (state == RF_CLEAR) begin
      clr_ptr <= clr_ptr + 1'b1;
      if (clr_ptr == LAST) state <= RF_RUN;
    end
  end

  always_comb begin
    wr_ok = '0;
    for (int unsigned i = 0; i < NUM_WR; i++) begin
      wr_ok[i] = run && wr_en[i] && rf_addr_ok(32'(wr_addr[i]), NREGS, ZERO_X0);
    end
  end

  // No reset on the array: the clear engine zeroes it so it can map to RAM.
  // Ascending loop with non-blocking writes lets the highest-index port win.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state == RF_CLEAR) begin
        mem[clr_ptr] <= '0;
      end else begin
        for (int unsigned i = 0; i < NUM_WR; i++) begin
          if (wr_ok[i]) mem[wr_addr[i]] <= wr_data[i];
        end
      end
    end
  end

  always_comb begin
    rd_data = '0;
    rd_ok   = '0;
    rd_hit  = '0;
    for (int unsigned r = 0; r < NUM_RD; r++) begin
      fwd_data[r] = '0;
      rd_ok[r]    = run && rf_addr_ok(32'(rd_addr[r]), NREGS, ZERO_X0);
      for (int unsigned i = 0; i < NUM_WR; i++) begin
        if (wr_ok[i] && (wr_addr[i] == rd_addr[r])) begin
          rd_hit[r]   = 1'b1;
          fwd_data[r] = wr_data[i];
        end
      end
      if (rd_ok[r]) rd_data[r] = (FWD_EN && rd_hit[r]) ? fwd_data[r] : mem[rd_addr[r]];
    end
  end

  rf_scoreboard #(
    .NREGS  (NREGS),
    .AW     (AW),
    .NUM_RD (NUM_RD),
    .NUM_WR (NUM_WR),
    .ZERO_X0(ZERO_X0),
    .FWD_EN (FWD_EN)
  ) u_scoreboard (
    .clk       (clk),
    .rst       (rst),
    .clear_last(clear_last),
    .ready     (ready),
    .wr_ok     (wr_ok),
    .wr_addr   (wr_addr),
    .alloc_en  (alloc_en),
    .alloc_addr(alloc_addr),
    .flush     (flush),
    .rd_addr   (rd_addr),
    .rd_ok     (rd_ok),
    .rd_hit    (rd_hit),
    .rd_busy   (rd_busy)
  );

endmodule

// File: tb/tb_regfile_mp.sv
// Bench for regfile_mp: three instances (default, ZERO_X0=0, FWD_EN=0) share one stimulus stream.
module tb_regfile_mp;

  localparam int unsigned AW = 5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                 rst;
  logic [1:0][AW-1:0]   rd_addr;
  logic [1:0]           wr_en;
  logic [1:0][AW-1:0]   wr_addr;
  logic [1:0][31:0]     wr_data;
  logic                 alloc_en;
  logic [AW-1:0]        alloc_addr;
  logic                 flush;

  logic                 ready_a, ready_b, ready_c;
  logic [1:0][31:0]     data_a, data_b, data_c;
  logic [1:0]           busy_a, busy_b, busy_c;

  regfile_mp dut_a (
    .clk(clk), .rst(rst), .ready(ready_a), .rd_addr(rd_addr), .rd_data(data_a),
    .rd_busy(busy_a), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .alloc_en(alloc_en), .alloc_addr(alloc_addr), .flush(flush)
  );

  regfile_mp #(.ZERO_X0(1'b0)) dut_b (
    .clk(clk), .rst(rst), .ready(ready_b), .rd_addr(rd_addr), .rd_data(data_b),
    .rd_busy(busy_b), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .alloc_en(alloc_en), .alloc_addr(alloc_addr), .flush(flush)
  );

  regfile_mp #(.FWD_EN(1'b0)) dut_c (
    .clk(clk), .rst(rst), .ready(ready_c), .rd_addr(rd_addr), .rd_data(data_c),
    .rd_busy(busy_c), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .alloc_en(alloc_en), .alloc_addr(alloc_addr), .flush(flush)
  );

  typedef enum int {
    RDY_A, RDY_B, RDY_C,
    DAT_A0, DAT_A1, DAT_B0, DAT_B1, DAT_C0, DAT_C1,
    BSY_A0, BSY_A1, BSY_B0, BSY_B1, BSY_C0, BSY_C1
  } obs_e;

  typedef struct {
    string       name;
    obs_e        sel;
    logic [31:0] val;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  function automatic logic [31:0] obs(input obs_e s);
    case (s)
      RDY_A:  return {31'b0, ready_a};
      RDY_B:  return {31'b0, ready_b};
      RDY_C:  return {31'b0, ready_c};
      DAT_A0: return data_a[0];
      DAT_A1: return data_a[1];
      DAT_B0: return data_b[0];
      DAT_B1: return data_b[1];
      DAT_C0: return data_c[0];
      DAT_C1: return data_c[1];
      BSY_A0: return {31'b0, busy_a[0]};
      BSY_A1: return {31'b0, busy_a[1]};
      BSY_B0: return {31'b0, busy_b[0]};
      BSY_B1: return {31'b0, busy_b[1]};
      BSY_C0: return {31'b0, busy_c[0]};
      BSY_C1: return {31'b0, busy_c[1]};
      default: return 32'hxxxx_xxxx;
    endcase
  endfunction

  task automatic push_exp(input string name, input obs_e sel, input logic [31:0] val);
    q.push_back('{name, sel, val});
  endtask

  task automatic idle();
    wr_en      = '0;
    wr_addr    = '0;
    wr_data    = '0;
    alloc_en   = 1'b0;
    alloc_addr = '0;
    flush      = 1'b0;
    rd_addr    = '0;
  endtask

  task automatic test_reset();
    exp_t e;
    rst = 1'b1;
    idle();
    for (int c = 0; c < 35; c++) begin
      @(negedge clk);
      idle();
      rd_addr[0] = 5'd12;
      if (c < 3) begin
        push_exp("rst_ready_a", RDY_A, 32'd0);
        push_exp("rst_ready_c", RDY_C, 32'd0);
        push_exp("rst_data_a", DAT_A0, 32'd0);
        push_exp("rst_busy_a", BSY_A0, 32'd0);
      end else if (c < 34) begin
        push_exp("clear_ready_a", RDY_A, 32'd0);
        if (c < 23) begin
          wr_en      = 2'b01;
          wr_addr[0] = 5'd12;
          wr_data[0] = 32'h0000_0099;
          alloc_en   = 1'b1;
          alloc_addr = 5'd12;
          push_exp("clear_data_a", DAT_A0, 32'd0);
          push_exp("clear_data_b", DAT_B0, 32'd0);
          push_exp("clear_busy_a", BSY_A0, 32'd0);
        end
      end else begin
        push_exp("ready_a", RDY_A, 32'd1);
        push_exp("ready_b", RDY_B, 32'd1);
        push_exp("ready_c", RDY_C, 32'd1);
        push_exp("clear_wr_lost_a", DAT_A0, 32'd0);
        push_exp("clear_wr_lost_b", DAT_B0, 32'd0);
        push_exp("clear_wr_lost_c", DAT_C0, 32'd0);
        push_exp("clear_alloc_lost_a", BSY_A0, 32'd0);
        push_exp("clear_alloc_lost_b", BSY_B0, 32'd0);
      end
      #1;
      while (q.size() > 0) begin
        e = q.pop_front();
        n_checks++;
        if (obs(e.sel) !== e.val) begin
          n_fail++;
          $display("FAIL %s (step %0d): got %h expected %h", e.name, c, obs(e.sel), e.val);
        end
      end
      if (c == 2) rst = 1'b0;
    end
  endtask

  task automatic test_fwd_priority();
    exp_t e;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      idle();
      rd_addr[0] = 5'd5;
      rd_addr[1] = 5'd5;
      if (c == 0) begin
        wr_en      = 2'b11;
        wr_addr[0] = 5'd5;
        wr_data[0] = 32'hAAAA_0000;
        wr_addr[1] = 5'd5;
        wr_data[1] = 32'h5555_FFFF;
        push_exp("fwd_hi_port_a", DAT_A0, 32'h5555_FFFF);
        push_exp("fwd_hi_port_b", DAT_B0, 32'h5555_FFFF);
        push_exp("nofwd_old_c", DAT_C0, 32'd0);
      end else begin
        push_exp("mem_hi_port_a", DAT_A0, 32'h5555_FFFF);
        push_exp("mem_hi_port_b1", DAT_B1, 32'h5555_FFFF);
        push_exp("mem_hi_port_c1", DAT_C1, 32'h5555_FFFF);
      end
      #1;
      while (q.size() > 0) begin
        e = q.pop_front();
        n_checks++;
        if (obs(e.sel) !== e.val) begin
          n_fail++;
          $display("FAIL %s (step %0d): got %h expected %h", e.name, c, obs(e.sel), e.val);
        end
      end
    end
  endtask

  task automatic test_x0();
    exp_t e;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      idle();
      rd_addr[0] = 5'd0;
      if (c == 0) begin
        wr_en      = 2'b01;
        wr_addr[0] = 5'd0;
        wr_data[0] = 32'hDEAD_BEEF;
        alloc_en   = 1'b1;
        alloc_addr = 5'd0;
        push_exp("x0_data_same_a", DAT_A0, 32'd0);
        push_exp("x0_busy_same_a", BSY_A0, 32'd0);
        push_exp("x0_fwd_nz_b", DAT_B0, 32'hDEAD_BEEF);
        push_exp("x0_data_same_c", DAT_C0, 32'd0);
      end else begin
        push_exp("x0_data_next_a", DAT_A0, 32'd0);
        push_exp("x0_busy_next_a", BSY_A0, 32'd0);
        push_exp("x0_mem_nz_b", DAT_B0, 32'hDEAD_BEEF);
        push_exp("x0_busy_nz_b", BSY_B0, 32'd1);
      end
      #1;
      while (q.size() > 0) begin
        e = q.pop_front();
        n_checks++;
        if (obs(e.sel) !== e.val) begin
          n_fail++;
          $display("FAIL %s (step %0d): got %h expected %h", e.name, c, obs(e.sel), e.val);
        end
      end
    end
  endtask

  task automatic test_scoreboard();
    exp_t e;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      idle();
      rd_addr[0] = 5'd7;
      case (c)
        0: begin
          alloc_en   = 1'b1;
          alloc_addr = 5'd7;
          push_exp("alloc_not_yet_a", BSY_A0, 32'd0);
        end
        1: begin
          push_exp("alloc_busy_a", BSY_A0, 32'd1);
          push_exp("alloc_busy_c", BSY_C0, 32'd1);
        end
        2: begin
          wr_en      = 2'b01;
          wr_addr[0] = 5'd7;
          wr_data[0] = 32'h0000_0012;
          push_exp("wr_mask_busy_a", BSY_A0, 32'd0);
          push_exp("wr_nomask_busy_c", BSY_C0, 32'd1);
          push_exp("wr_fwd_data_a", DAT_A0, 32'h0000_0012);
          push_exp("wr_nofwd_data_c", DAT_C0, 32'd0);
        end
        3: begin
          push_exp("wr_cleared_a", BSY_A0, 32'd0);
          push_exp("wr_cleared_c", BSY_C0, 32'd0);
          push_exp("wr_mem_c", DAT_C0, 32'h0000_0012);
        end
        4: begin
          wr_en      = 2'b10;
          wr_addr[1] = 5'd7;
          wr_data[1] = 32'h0000_0034;
          alloc_en   = 1'b1;
          alloc_addr = 5'd7;
          push_exp("alloc_wr_fwd_a", DAT_A0, 32'h0000_0034);
        end
        default: begin
          push_exp("alloc_beats_wr_a", BSY_A0, 32'd1);
          push_exp("alloc_beats_wr_c", BSY_C0, 32'd1);
          push_exp("alloc_wr_mem_a", DAT_A0, 32'h0000_0034);
        end
      endcase
      #1;
      while (q.size() > 0) begin
        e = q.pop_front();
        n_checks++;
        if (obs(e.sel) !== e.val) begin
          n_fail++;
          $display("FAIL %s (step %0d): got %h expected %h", e.name, c, obs(e.sel), e.val);
        end
      end
    end
  endtask

  task automatic test_flush();
    exp_t e;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      idle();
      case (c)
        0: begin alloc_en = 1'b1; alloc_addr = 5'd3; end
        1: begin
          alloc_en = 1'b1; alloc_addr = 5'd4; rd_addr[0] = 5'd3;
          push_exp("busy_x3", BSY_A0, 32'd1);
        end
        2: begin
          alloc_en = 1'b1; alloc_addr = 5'd9; rd_addr[0] = 5'd4; rd_addr[1] = 5'd3;
          push_exp("busy_x4", BSY_A0, 32'd1);
          push_exp("busy_x3_held", BSY_A1, 32'd1);
        end
        3: begin
          flush = 1'b1; alloc_en = 1'b1; alloc_addr = 5'd10;
          rd_addr[0] = 5'd9; rd_addr[1] = 5'd7;
          push_exp("busy_x9", BSY_A0, 32'd1);
          push_exp("busy_x7_pre_flush", BSY_A1, 32'd1);
        end
        4: begin
          rd_addr[0] = 5'd10; rd_addr[1] = 5'd3;
          push_exp("flush_beats_alloc_a", BSY_A0, 32'd0);
          push_exp("flush_beats_alloc_b", BSY_B0, 32'd0);
          push_exp("flush_x3_a", BSY_A1, 32'd0);
          push_exp("flush_x3_b", BSY_B1, 32'd0);
          push_exp("flush_x3_c", BSY_C1, 32'd0);
        end
        default: begin
          rd_addr[0] = 5'd9; rd_addr[1] = 5'd7;
          push_exp("flush_x9_a", BSY_A0, 32'd0);
          push_exp("flush_x7_a", BSY_A1, 32'd0);
          push_exp("flush_x9_c", BSY_C0, 32'd0);
        end
      endcase
      #1;
      while (q.size() > 0) begin
        e = q.pop_front();
        n_checks++;
        if (obs(e.sel) !== e.val) begin
          n_fail++;
          $display("FAIL %s (step %0d): got %h expected %h", e.name, c, obs(e.sel), e.val);
        end
      end
    end
  endtask

  task automatic test_no_fwd();
    exp_t e;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      idle();
      rd_addr[0] = 5'd12;
      if (c == 0) begin
        wr_en      = 2'b10;
        wr_addr[1] = 5'd12;
        wr_data[1] = 32'h0000_0077;
        push_exp("nofwd_old_c", DAT_C0, 32'd0);
        push_exp("fwd_new_a", DAT_A0, 32'h0000_0077);
      end else begin
        push_exp("nofwd_next_c", DAT_C0, 32'h0000_0077);
        push_exp("fwd_next_a", DAT_A0, 32'h0000_0077);
      end
      #1;
      while (q.size() > 0) begin
        e = q.pop_front();
        n_checks++;
        if (obs(e.sel) !== e.val) begin
          n_fail++;
          $display("FAIL %s (step %0d): got %h expected %h", e.name, c, obs(e.sel), e.val);
        end
      end
    end
  endtask

  task automatic test_mid_reset();
    exp_t e;
    for (int c = 0; c < 43; c++) begin
      @(negedge clk);
      idle();
      rd_addr[0] = 5'd5;
      rd_addr[1] = 5'd7;
      if (c == 0) begin
        push_exp("pre_rst_ready_a", RDY_A, 32'd1);
        push_exp("pre_rst_data_a", DAT_A0, 32'h5555_FFFF);
      end else if (c == 5) begin
        alloc_en   = 1'b1;
        alloc_addr = 5'd7;
      end else if (c == 6) begin
        push_exp("pre_rst_busy_a", BSY_A1, 32'd1);
      end else if (c >= 10 && c < 42) begin
        push_exp("mid_rst_ready_a", RDY_A, 32'd0);
        if (c == 10) push_exp("mid_rst_data_a", DAT_A0, 32'd0);
      end else if (c == 42) begin
        push_exp("post_rst_ready_a", RDY_A, 32'd1);
        push_exp("post_rst_ready_c", RDY_C, 32'd1);
        push_exp("post_rst_data_a", DAT_A0, 32'd0);
        push_exp("post_rst_data_b", DAT_B0, 32'd0);
        push_exp("post_rst_busy_a", BSY_A1, 32'd0);
      end
      #1;
      while (q.size() > 0) begin
        e = q.pop_front();
        n_checks++;
        if (obs(e.sel) !== e.val) begin
          n_fail++;
          $display("FAIL %s (step %0d): got %h expected %h", e.name, c, obs(e.sel), e.val);
        end
      end
      if (c == 9) rst = 1'b1;
      if (c == 10) rst = 1'b0;
    end
  endtask

  initial begin
    test_reset();
    test_fwd_priority();
    test_x0();
    test_scoreboard();
    test_flush();
    test_no_fwd();
    test_mid_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, got running expected finished");
    $fatal(1);
  end

endmodule

// File: doc/regfile_mp.md
# regfile_mp

Parametrised multi-port integer register file for the superscalar pipeline, replacing the single-write, dual-read register file. It provides NUM_RD asynchronous read ports and NUM_WR synchronous write ports with write-through forwarding, and an optional x0 hardwire. A per-register busy scoreboard lets the issue stage detect pending writers. A post-reset clear engine zeroes storage one entry per cycle, so the array maps to RAM without a parallel reset.

## Interface
- XLEN: default riscv_pkg XLEN (32); data width
- NREGS: default riscv_pkg REG_SIZE (32); number of registers; AW = $clog2(NREGS)
- NUM_RD: default 2; read ports
- NUM_WR: default 2; write ports; higher index = higher priority
- ZERO_X0: default 1; 1 = address 0 hardwired to zero
- FWD_EN: default 1; 1 = same-cycle write-through forwarding on reads
- clk  in  1  clock; all state on posedge
- rst  in  1  synchronous, active-high reset
- ready  out  1  high when clear engine is done and ports are live
- rd_addr  in  NUM_RD x AW  read addresses
- rd_data  out  NUM_RD x XLEN  read data (combinational)
- rd_busy  out  NUM_RD  scoreboard busy bit for each read address (combinational)
- wr_en  in  NUM_WR  write enables
- wr_addr  in  NUM_WR x AW  write addresses
- wr_data  in  NUM_WR x XLEN  write data
- alloc_en  in  1  mark alloc_addr busy (instruction issued with destination)
- alloc_addr  in  AW  register being allocated
- flush  in  1  clear all busy bits (pipeline flush)

## Operation
- States: CLEAR, RUN. rst forces CLEAR with clr_ptr=0 and all busy bits 0. This applies mid-operation too: any rst restarts the clear.
- CLEAR: each cycle with rst low writes 0 to mem[clr_ptr] and increments clr_ptr. Writing entry NREGS-1 moves to RUN.
- In CLEAR: wr_en, alloc_en and flush are ignored; rd_data=0; rd_busy=0.
- RUN write: every wr_en[i] with a legal address writes mem[wr_addr[i]] on the posedge.
  - Two or more ports to the same address: the highest-index port wins.
  - ZERO_X0=1: writes to address 0 are dropped.
- RUN read: if ZERO_X0 and addr==0, return 0. Else if FWD_EN and any wr_en[i] matches addr this cycle, return wr_data of the highest-index matching port. Else return mem[addr].
- Busy update order, lowest to highest priority:
  - wr_en[i] clears busy[wr_addr[i]];
  - alloc_en sets busy[alloc_addr] (alloc beats write to the same register in the same cycle);
  - flush clears all bits (beats alloc).
- Address 0 with ZERO_X0=1 is never busy.
- rd_busy = busy[addr], forced to 0 when FWD_EN and a same-cycle write matches (the value is already being forwarded).
- Addresses at or above NREGS (non-power-of-2 NREGS): writes and allocs are dropped; reads return 0, not busy.

## Timing
- Reset values: ready=0, all busy=0, state=CLEAR, clr_ptr=0. rd_data=0 and rd_busy=0 while not ready.
- ready is registered and rises exactly NREGS cycles after the first rising edge with rst low.
- Read latency is 0 (combinational). A write is visible via mem on the cycle after its edge, or the same cycle through forwarding.
- Alloc is visible on rd_busy the cycle after alloc_en. A write-clear is visible the same cycle through the forwarding mask and in storage the next cycle.
- There is no backpressure. Inputs presented while ready=0 are lost; the issue stage must gate on ready.

## Structure
- riscv_pkg adds:
  - rf_state_e enum {RF_CLEAR, RF_RUN};
  - localparam RF_NUM_RD=2 and RF_NUM_WR=2 as shared defaults.
- Sub-module rf_scoreboard holds the busy bit vector, alloc/clear/flush priority and ready gating. regfile_mp holds storage, write arbitration, forwarding and the clear FSM.

## Test plan
- Reset, NREGS=32: hold rst 3 cycles, release -> ready=0 for 32 cycles, ready=1 on cycle 32; all reads return 0; rst pulse at cycle 10 of RUN restarts the 32-cycle clear.
- wr port0 x5=0xAAAA0000 and port1 x5=0x5555FFFF same cycle, rd_addr0=5 -> same-cycle rd_data0=0x5555FFFF (forwarded); next cycle mem value 0x5555FFFF.
- Write x0=0xDEADBEEF and alloc x0 with ZERO_X0=1 -> rd x0 returns 0 and rd_busy=0 both cycles. With ZERO_X0=0 -> reads 0xDEADBEEF next cycle.
- Scoreboard:
  - alloc x7 -> rd_busy(7)=1 next cycle;
  - write x7=0x12 -> rd_busy=0 the same cycle, busy clear the next;
  - alloc x7 plus write x7 same cycle -> busy stays 1.
- Alloc x3, x4, x9 in turn, then flush with alloc x10 same cycle -> all busy 0 next cycle, including x10.
- FWD_EN=0: write x12=0x77 and read x12 same cycle -> old value 0; 0x77 on the next cycle. Writes issued during CLEAR never appear.
